// File: rtl/branch_pred_client_pkg.sv
// rtl/branch_pred_client_pkg.sv - shared types for the branch predictor client
// Purpose: PC type, FSM state enum, saved-branch record and a PC increment helper.
// Ports: none (package).
package pred_pkg;

   localparam int PC_W = 15;

   typedef logic [PC_W-1:0] pc_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } bpc_state_t;

   typedef struct packed {
      pc_t  pc;
      pc_t  target;
      logic pred;
   } pending_t;

   // Wraps modulo 2^PC_W, so the last word falls through to 0.
   function automatic pc_t pc_inc(input pc_t pc, input pc_t step);
      return pc + step;
   endfunction

endpackage

// File: rtl/branch_pred_client_if.sv
// rtl/branch_pred_client_if.sv - IPredictor interface between fetch client and predictor
// Purpose: prediction request/response and resolve update channel.
// Ports (master view): pred_en/pred_pc request a prediction, pred_taken returns it
//   in the same cycle; rslt_en/rslt_pc/rslt_taken report a resolved branch.
interface IPredictor;
   import pred_pkg::*;

   logic pred_en;
   pc_t  pred_pc;
   logic pred_taken;
   logic rslt_en;
   pc_t  rslt_pc;
   logic rslt_taken;

   modport master (
      output pred_en, pred_pc, rslt_en, rslt_pc, rslt_taken,
      input  pred_taken
   );

   modport slave (
      input  pred_en, pred_pc, rslt_en, rslt_pc, rslt_taken,
      output pred_taken
   );

endinterface

// File: rtl/branch_pred_client_stat_counter.sv
// rtl/branch_pred_client_stat_counter.sv - saturating event counter
// Purpose: counts cycles with en high, sticking at all-ones.
// Ports: clk, reset (async, active-high), en (count enable), count (current value).
module pred_stat_counter #(
   parameter int STAT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic [STAT_W-1:0] count
);

   logic [STAT_W-1:0] count_q;
   logic [STAT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (en && (count_q != {STAT_W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/branch_pred_client.sv
// rtl/branch_pred_client.sv - fetch-stage master of the IPredictor interface
// Purpose: requests a prediction per fetched branch, computes the predicted next
//   PC, tracks the single outstanding branch, reports its outcome to the predictor
//   and issues a registered redirect on mispredict.
// Optional feature: BRANCH_STATS_EN adds resolved-branch and mispredict counters.
// Ports:
//   clk, reset                      clock, async active-high reset
//   f_valid/f_pc/f_is_branch/f_target   fetch slot inputs
//   f_stall/f_pred_taken/f_next_pc      fetch hold, prediction, predicted next PC
//   r_valid/r_pc/r_taken                resolve from execute
//   flush                               external pipeline flush
//   redirect/redirect_pc                one-cycle correct-path refetch
//   proto_err                           sticky unmatched-resolve flag
//   stat_branches/stat_mispred          statistics (zero without BRANCH_STATS_EN)
//   predict                             IPredictor master modport
module branch_pred_client
   import pred_pkg::*;
#(
   parameter int PC_W    = 15,
   parameter int PC_STEP = 1,
   parameter int STAT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_valid,
   input  logic [PC_W-1:0]   f_pc,
   input  logic              f_is_branch,
   input  logic [PC_W-1:0]   f_target,
   output logic              f_stall,
   output logic              f_pred_taken,
   output logic [PC_W-1:0]   f_next_pc,
   input  logic              r_valid,
   input  logic [PC_W-1:0]   r_pc,
   input  logic              r_taken,
   input  logic              flush,
   output logic              redirect,
   output logic [PC_W-1:0]   redirect_pc,
   output logic              proto_err,
   output logic [STAT_W-1:0] stat_branches,
   output logic [STAT_W-1:0] stat_mispred,
   IPredictor.master         predict
);

   localparam pc_t STEP = pc_t'(PC_STEP);

   bpc_state_t state_q, state_d;
   pending_t   saved_q, saved_d;
   logic       redirect_q, redirect_d;
   pc_t        redirect_pc_q, redirect_pc_d;
   logic       proto_err_q, proto_err_d;

   logic hit;
   logic correct;
   logic accept;
   logic rslt_fire;

   assign hit     = r_valid && (state_q == PENDING) && (r_pc == saved_q.pc);
   assign correct = (r_taken == saved_q.pred);

   // A correct resolve frees the slot in the same cycle, so a branch fetched
   // alongside it can be accepted; a mispredicting resolve means this fetch is
   // on the wrong path and must hold.
   assign f_stall = f_valid && f_is_branch &&
                    (((state_q == PENDING) && !(hit && correct)) || (hit && !correct));

   assign accept    = f_valid && f_is_branch && !f_stall && !flush;
   assign rslt_fire = hit && !flush;

   assign f_pred_taken = predict.pred_taken;
   assign f_next_pc    = (f_is_branch && predict.pred_taken) ? f_target : pc_inc(f_pc, STEP);

   assign predict.pred_en    = accept && !reset;
   assign predict.pred_pc    = f_pc;
   assign predict.rslt_en    = rslt_fire && !reset;
   assign predict.rslt_pc    = saved_q.pc;
   assign predict.rslt_taken = r_taken;

   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      if (flush) begin
         state_d = IDLE;
      end else if (accept) begin
         state_d        = PENDING;
         saved_d.pc     = f_pc;
         saved_d.target = f_target;
         saved_d.pred   = predict.pred_taken;
      end else if (hit) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      redirect_d    = rslt_fire && !correct;
      redirect_pc_d = redirect_pc_q;
      if (redirect_d) begin
         redirect_pc_d = r_taken ? saved_q.target : pc_inc(saved_q.pc, STEP);
      end
      proto_err_d = proto_err_q || (r_valid && !hit);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         saved_q       <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         saved_q       <= saved_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign proto_err   = proto_err_q;

`ifdef BRANCH_STATS_EN
   pred_stat_counter #(.STAT_W(STAT_W)) u_stat_branches (
      .clk   (clk),
      .reset (reset),
      .en    (rslt_fire),
      .count (stat_branches)
   );

   pred_stat_counter #(.STAT_W(STAT_W)) u_stat_mispred (
      .clk   (clk),
      .reset (reset),
      .en    (rslt_fire && !correct),
      .count (stat_mispred)
   );
`else
   assign stat_branches = '0;
   assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_pred_client.sv
// tb/tb_branch_pred_client.sv - directed bench for branch_pred_client
module tb_branch_pred_client;

   logic        clk;
   logic        reset;
   logic        f_valid;
   logic [14:0] f_pc;
   logic        f_is_branch;
   logic [14:0] f_target;
   logic        f_stall;
   logic        f_pred_taken;
   logic [14:0] f_next_pc;
   logic        r_valid;
   logic [14:0] r_pc;
   logic        r_taken;
   logic        flush;
   logic        redirect;
   logic [14:0] redirect_pc;
   logic        proto_err;
   logic [31:0] stat_branches;
   logic [31:0] stat_mispred;

   IPredictor bp ();

   branch_pred_client #(.PC_W(15), .PC_STEP(1), .STAT_W(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .f_valid       (f_valid),
      .f_pc          (f_pc),
      .f_is_branch   (f_is_branch),
      .f_target      (f_target),
      .f_stall       (f_stall),
      .f_pred_taken  (f_pred_taken),
      .f_next_pc     (f_next_pc),
      .r_valid       (r_valid),
      .r_pc          (r_pc),
      .r_taken       (r_taken),
      .flush         (flush),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .proto_err     (proto_err),
      .stat_branches (stat_branches),
      .stat_mispred  (stat_mispred),
      .predict       (bp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fv;
      logic [14:0] fpc;
      logic        fb;
      logic [14:0] ftg;
      logic        pt;
      logic        rv;
      logic [14:0] rpc;
      logic        rt;
      logic        fl;
      logic        e_stall;
      logic        e_fpt;
      logic [14:0] e_nxt;
      logic        e_pen;
      logic        e_ren;
      logic [14:0] e_rpc;
      logic        e_rt;
      logic        e_red;
      logic [14:0] e_redpc;
      logic        e_perr;
   } vec_t;

   vec_t vecs [24];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      f_valid        = v.fv;
      f_pc           = v.fpc;
      f_is_branch    = v.fb;
      f_target       = v.ftg;
      bp.pred_taken  = v.pt;
      r_valid        = v.rv;
      r_pc           = v.rpc;
      r_taken        = v.rt;
      flush          = v.fl;
   endtask

   task automatic idle_inputs();
      f_valid = 0; f_pc = '0; f_is_branch = 0; f_target = '0; bp.pred_taken = 0;
      r_valid = 0; r_pc = '0; r_taken = 0; flush = 0;
   endtask

   initial begin
      //          fv fpc       fb ftg       pt rv rpc       rt fl  stl fpt nxt       pen ren rpc       rt red redpc     perr
      vecs[0]  = '{0, 15'h0000, 0, 15'h0000, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0001, 0, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[1]  = '{1, 15'h0010, 1, 15'h0040, 1, 0, 15'h0000, 0, 0,  0, 1, 15'h0040, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[2]  = '{0, 15'h0020, 0, 15'h0000, 0, 1, 15'h0010, 1, 0,  0, 0, 15'h0021, 0, 1, 15'h0010, 1, 0, 15'h0000, 0};
      vecs[3]  = '{0, 15'h0000, 0, 15'h0000, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0001, 0, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[4]  = '{1, 15'h0010, 1, 15'h0040, 1, 0, 15'h0000, 0, 0,  0, 1, 15'h0040, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[5]  = '{1, 15'h0050, 1, 15'h0060, 0, 1, 15'h0010, 0, 0,  1, 0, 15'h0051, 0, 1, 15'h0010, 0, 0, 15'h0000, 0};
      vecs[6]  = '{0, 15'h0000, 0, 15'h0000, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0001, 0, 0, 15'h0000, 0, 1, 15'h0011, 0};
      vecs[7]  = '{1, 15'h0100, 1, 15'h0200, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0101, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[8]  = '{1, 15'h0300, 1, 15'h0400, 1, 0, 15'h0000, 0, 0,  1, 1, 15'h0400, 0, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[9]  = '{1, 15'h0300, 1, 15'h0400, 1, 1, 15'h0100, 0, 0,  0, 1, 15'h0400, 1, 1, 15'h0100, 0, 0, 15'h0000, 0};
      vecs[10] = '{0, 15'h0000, 0, 15'h0000, 0, 1, 15'h0300, 1, 0,  0, 0, 15'h0001, 0, 1, 15'h0300, 1, 0, 15'h0000, 0};
      vecs[11] = '{1, 15'h7FFF, 1, 15'h1234, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0000, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[12] = '{0, 15'h0000, 0, 15'h0000, 0, 1, 15'h7FFF, 0, 0,  0, 0, 15'h0001, 0, 1, 15'h7FFF, 0, 0, 15'h0000, 0};
      vecs[13] = '{1, 15'h7FFF, 1, 15'h1234, 1, 0, 15'h0000, 0, 0,  0, 1, 15'h1234, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[14] = '{0, 15'h0000, 0, 15'h0000, 0, 1, 15'h7FFF, 0, 0,  0, 0, 15'h0001, 0, 1, 15'h7FFF, 0, 0, 15'h0000, 0};
      vecs[15] = '{1, 15'h7FFF, 0, 15'h0000, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0000, 0, 0, 15'h0000, 0, 1, 15'h0000, 0};
      vecs[16] = '{1, 15'h0020, 1, 15'h0030, 1, 0, 15'h0000, 0, 0,  0, 1, 15'h0030, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[17] = '{0, 15'h0000, 0, 15'h0000, 0, 1, 15'h0020, 0, 1,  0, 0, 15'h0001, 0, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[18] = '{1, 15'h0040, 1, 15'h0044, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0041, 1, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[19] = '{0, 15'h0000, 0, 15'h0000, 0, 1, 15'h0040, 0, 0,  0, 0, 15'h0001, 0, 1, 15'h0040, 0, 0, 15'h0000, 0};
      vecs[20] = '{0, 15'h0000, 0, 15'h0000, 0, 1, 15'h0123, 0, 0,  0, 0, 15'h0001, 0, 0, 15'h0000, 0, 0, 15'h0000, 0};
      vecs[21] = '{0, 15'h0000, 0, 15'h0000, 0, 0, 15'h0000, 0, 0,  0, 0, 15'h0001, 0, 0, 15'h0000, 0, 0, 15'h0000, 1};
      vecs[22] = '{1, 15'h0050, 1, 15'h0060, 1, 0, 15'h0000, 0, 1,  0, 1, 15'h0060, 0, 0, 15'h0000, 0, 0, 15'h0000, 1};
      vecs[23] = '{1, 15'h0050, 1, 15'h0060, 1, 0, 15'h0000, 0, 0,  0, 1, 15'h0060, 1, 0, 15'h0000, 0, 0, 15'h0000, 1};

      // Reset with a branch presented: requests must stay suppressed.
      reset = 1'b1;
      idle_inputs();
      f_valid = 1; f_is_branch = 1; f_pc = 15'h0010; f_target = 15'h0040;
      @(negedge clk);
      chk("reset pred_en", {31'd0, bp.pred_en}, 32'd0);
      chk("reset rslt_en", {31'd0, bp.rslt_en}, 32'd0);
      chk("reset redirect", {31'd0, redirect}, 32'd0);
      chk("reset redirect_pc", {17'd0, redirect_pc}, 32'd0);
      chk("reset proto_err", {31'd0, proto_err}, 32'd0);
      chk("reset stat_branches", stat_branches, 32'd0);
      chk("reset stat_mispred", stat_mispred, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      reset = 1'b0;

      for (int i = 0; i < 24; i++) begin
         @(posedge clk);
         #1;
         drive(vecs[i]);
         @(negedge clk);
         chk($sformatf("v%0d f_stall", i), {31'd0, f_stall}, {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d f_pred_taken", i), {31'd0, f_pred_taken}, {31'd0, vecs[i].e_fpt});
         chk($sformatf("v%0d f_next_pc", i), {17'd0, f_next_pc}, {17'd0, vecs[i].e_nxt});
         chk($sformatf("v%0d pred_en", i), {31'd0, bp.pred_en}, {31'd0, vecs[i].e_pen});
         if (vecs[i].e_pen)
            chk($sformatf("v%0d pred_pc", i), {17'd0, bp.pred_pc}, {17'd0, vecs[i].fpc});
         chk($sformatf("v%0d rslt_en", i), {31'd0, bp.rslt_en}, {31'd0, vecs[i].e_ren});
         if (vecs[i].e_ren) begin
            chk($sformatf("v%0d rslt_pc", i), {17'd0, bp.rslt_pc}, {17'd0, vecs[i].e_rpc});
            chk($sformatf("v%0d rslt_taken", i), {31'd0, bp.rslt_taken}, {31'd0, vecs[i].e_rt});
         end
         chk($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_red});
         if (vecs[i].e_red)
            chk($sformatf("v%0d redirect_pc", i), {17'd0, redirect_pc}, {17'd0, vecs[i].e_redpc});
         chk($sformatf("v%0d proto_err", i), {31'd0, proto_err}, {31'd0, vecs[i].e_perr});
      end

`ifdef BRANCH_STATS_EN
      chk("stat_branches", stat_branches, 32'd7);
      chk("stat_mispred", stat_mispred, 32'd2);
`else
      chk("stat_branches tied", stat_branches, 32'd0);
      chk("stat_mispred tied", stat_mispred, 32'd0);
`endif

      // Reset while branch 0x50 is outstanding: it must be forgotten.
      @(posedge clk);
      #1;
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      chk("midreset proto_err", {31'd0, proto_err}, 32'd0);
      chk("midreset redirect", {31'd0, redirect}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      r_valid = 1; r_pc = 15'h0050; r_taken = 1;
      @(negedge clk);
      chk("dropped rslt_en", {31'd0, bp.rslt_en}, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      f_valid = 1; f_is_branch = 1; f_pc = 15'h0070; f_target = 15'h0010;
      @(negedge clk);
      chk("post-reset proto_err", {31'd0, proto_err}, 32'd1);
      chk("post-reset stall", {31'd0, f_stall}, 32'd0);
      chk("post-reset pred_en", {31'd0, bp.pred_en}, 32'd1);
      chk("post-reset next_pc", {17'd0, f_next_pc}, 32'h0071);
      @(posedge clk);
      #1;
      idle_inputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
